// File: rtl/pwm_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ctrl_pkg
// Description : Shared types and the clamped duty-step helper for the PWM
//               duty controller.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_ctrl_pkg;

    localparam int c_duty_w_default = 11;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SOFT_START = 2'd1,
        REGULATE   = 2'd2,
        FAULT      = 2'd3
    } pwm_ctrl_state_t;

    // One-LSB step toward up/down that saturates at the window edge instead of wrapping.
    function automatic int unsigned duty_step(input int unsigned duty,
                                              input logic        up,
                                              input int unsigned dmin,
                                              input int unsigned dmax);
        if (up) begin
            return (duty >= dmax) ? dmax : duty + 1;
        end
        return (duty <= dmin) ? dmin : duty - 1;
    endfunction

endpackage : pwm_ctrl_pkg
`default_nettype wire

// File: rtl/pwm_duty_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_controller_if
// Description : Control/feedback bundle between the duty controller (slave)
//               and its supervisor plus PWM core (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_duty_controller_if #(
    parameter int DUTY_W = 11
) ();

    logic              run;
    logic              fault_clr;
    logic              fb;
    logic [DUTY_W-1:0] duty;
    logic              en;
    logic              fault;
    logic              busy;

    modport master (
        output run, fault_clr, fb,
        input  duty, en, fault, busy
    );

    modport slave (
        input  run, fault_clr, fb,
        output duty, en, fault, busy
    );

endinterface : pwm_duty_controller_if
`default_nettype wire

// File: rtl/pwm_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : pwm_tick_divider
// Description : Free-running 0..DIV-1 counter with a one-cycle tick on the
//               terminal count; clr restarts the period from zero.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_tick_divider #(
    parameter int DIV = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    input  wire logic clr,
    output logic      tick
);

    localparam int c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;

    assign w_tick = (r_cnt == c_cnt_w'(DIV - 1));
    assign tick   = w_tick & ~clr;

    always_ff @(posedge clock) begin
        if (reset || clr || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule : pwm_tick_divider
`default_nettype wire

// File: rtl/pwm_duty_controller.sv
`default_nettype none
// ============================================================================
// Module      : pwm_duty_controller
// Description : Soft-start / closed-loop duty sequencer with saturation fault
//               latch. Soft-start ramp present only with PWM_CTRL_SOFT_START_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_controller
    import pwm_ctrl_pkg::*;
#(
    parameter int          DUTY_W     = c_duty_w_default,
    parameter int unsigned UPDATE_DIV = 15000,
    parameter int unsigned SS_DIV     = 60000,
    parameter int unsigned DUTY_MIN   = 0,
    parameter int unsigned DUTY_MAX   = 1900,
    parameter int unsigned FAULT_CNT  = 64
) (
    input  wire logic             clock,
    input  wire logic             reset,
    pwm_duty_controller_if.slave  bus
);

    localparam int          c_sat_w    = $clog2(FAULT_CNT + 1);
    localparam logic [DUTY_W-1:0] c_duty_max = DUTY_W'(DUTY_MAX);
    localparam logic [DUTY_W-1:0] c_duty_min = DUTY_W'(DUTY_MIN);

    if (DUTY_MIN > DUTY_MAX || DUTY_MAX >= (64'd1 << DUTY_W) ||
        UPDATE_DIV < 1 || SS_DIV < 1 || FAULT_CNT < 1) begin : g_param_check
        $error("pwm_duty_controller: inconsistent parameter set");
    end

    pwm_ctrl_state_t     r_state;
    logic [DUTY_W-1:0]   r_duty;
    logic                r_en;
    logic                r_fault;
    logic                r_busy;
    logic [c_sat_w-1:0]  r_sat_cnt;
    logic                r_fb_meta;
    logic                r_fb_s;

    logic                w_upd_tick;
    logic [DUTY_W-1:0]   w_duty_reg;
    logic                w_sat_hit;
    logic [c_sat_w-1:0]  w_sat_inc;
    logic                w_sat_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_fb_meta <= 1'b0;
            r_fb_s    <= 1'b0;
        end else begin
            r_fb_meta <= bus.fb;
            r_fb_s    <= r_fb_meta;
        end
    end

    // Dividers are held clear outside their own state, so each period restarts on entry.
    pwm_tick_divider #(
        .DIV (int'(UPDATE_DIV))
    ) u_update_div (
        .clock (clock),
        .reset (reset),
        .clr   (r_state != REGULATE),
        .tick  (w_upd_tick)
    );

`ifdef PWM_CTRL_SOFT_START_EN
    logic              w_ss_tick;
    logic [DUTY_W-1:0] w_duty_ss;

    pwm_tick_divider #(
        .DIV (int'(SS_DIV))
    ) u_ss_div (
        .clock (clock),
        .reset (reset),
        .clr   (r_state != SOFT_START),
        .tick  (w_ss_tick)
    );

    assign w_duty_ss = DUTY_W'(duty_step(32'(r_duty), 1'b1, 32'd0, DUTY_MAX));
`endif

    assign w_duty_reg = DUTY_W'(duty_step(32'(r_duty), ~r_fb_s, DUTY_MIN, DUTY_MAX));
    assign w_sat_hit  = (r_duty == c_duty_max) && !r_fb_s;
    assign w_sat_inc  = r_sat_cnt + c_sat_w'(1);
    assign w_sat_last = (w_sat_inc == c_sat_w'(FAULT_CNT));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_duty    <= '0;
            r_en      <= 1'b0;
            r_fault   <= 1'b0;
            r_busy    <= 1'b0;
            r_sat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.run) begin
`ifdef PWM_CTRL_SOFT_START_EN
                        r_state <= SOFT_START;
                        r_duty  <= '0;
`else
                        r_state <= REGULATE;
                        r_duty  <= c_duty_min;
`endif
                        r_en      <= 1'b1;
                        r_busy    <= 1'b1;
                        r_sat_cnt <= '0;
                    end
                end

`ifdef PWM_CTRL_SOFT_START_EN
                SOFT_START: begin
                    if (!bus.run) begin
                        r_state <= IDLE;
                        r_duty  <= '0;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_ss_tick) begin
                        if (r_fb_s || r_duty == c_duty_max) begin
                            r_state <= REGULATE;
                        end else begin
                            r_duty <= w_duty_ss;
                        end
                    end
                end
`endif

                REGULATE: begin
                    // A terminal saturated tick takes priority over a simultaneous stop request.
                    if (w_upd_tick && w_sat_hit && w_sat_last) begin
                        r_state   <= FAULT;
                        r_duty    <= '0;
                        r_en      <= 1'b0;
                        r_fault   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_sat_cnt <= '0;
                    end else if (!bus.run) begin
                        r_state   <= IDLE;
                        r_duty    <= '0;
                        r_en      <= 1'b0;
                        r_busy    <= 1'b0;
                        r_sat_cnt <= '0;
                    end else if (w_upd_tick) begin
                        r_duty    <= w_duty_reg;
                        r_sat_cnt <= w_sat_hit ? w_sat_inc : '0;
                    end
                end

                FAULT: begin
                    if (bus.fault_clr && !bus.run) begin
                        r_state <= IDLE;
                        r_fault <= 1'b0;
                    end
                end

                default: begin
                    r_state   <= IDLE;
                    r_duty    <= '0;
                    r_en      <= 1'b0;
                    r_fault   <= 1'b0;
                    r_busy    <= 1'b0;
                    r_sat_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.duty  = r_duty;
    assign bus.en    = r_en;
    assign bus.fault = r_fault;
    assign bus.busy  = r_busy;

endmodule : pwm_duty_controller
`default_nettype wire

// File: tb/tb_pwm_duty_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_duty_controller
// Description : Directed self-checking bench for pwm_duty_controller
//               (UPDATE_DIV=4, SS_DIV=8, DUTY_MIN=2, DUTY_MAX=20, FAULT_CNT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    pwm_duty_controller_if #(.DUTY_W(11)) bus ();

    pwm_duty_controller #(
        .DUTY_W     (11),
        .UPDATE_DIV (4),
        .SS_DIV     (8),
        .DUTY_MIN   (2),
        .DUTY_MAX   (20),
        .FAULT_CNT  (3)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int duty, input int en, input int fault, input int busy);
        chk({tag, ".duty"},  32'(bus.duty),  32'(duty));
        chk({tag, ".en"},    32'(bus.en),    32'(en));
        chk({tag, ".fault"}, 32'(bus.fault), 32'(fault));
        chk({tag, ".busy"},  32'(bus.busy),  32'(busy));
    endtask

    initial begin
        bus.run       = 1'b0;
        bus.fault_clr = 1'b0;
        bus.fb        = 1'b0;
        step(3);
        chk_out("reset", 0, 0, 0, 0);
        reset = 1'b0;
        step(2);
        chk_out("idle", 0, 0, 0, 0);

`ifdef PWM_CTRL_SOFT_START_EN
        // Soft-start ramp, then feedback-driven exit and regulation down to DUTY_MIN
        bus.run = 1'b1;
        step(1);  chk_out("enable", 0, 1, 0, 1);
        step(8);  chk("ss_d1", 32'(bus.duty), 1);
        step(8);  chk("ss_d2", 32'(bus.duty), 2);
        step(8);  chk("ss_d3", 32'(bus.duty), 3);
        step(16); chk("ss_d5", 32'(bus.duty), 5);
        bus.fb = 1'b1;
        step(8);  chk_out("ss_exit", 5, 1, 0, 1);
        step(4);  chk("reg_d4", 32'(bus.duty), 4);
        step(4);  chk("reg_d3", 32'(bus.duty), 3);
        step(4);  chk("reg_d2", 32'(bus.duty), 2);
        step(4);  chk("reg_hold_min", 32'(bus.duty), 2);
        bus.run = 1'b0;
        step(1);  chk_out("stop", 0, 0, 0, 0);
        bus.fb = 1'b0;
        step(3);

        // Saturation fault and release rules
        bus.run = 1'b1;
        step(1);
        step(160); chk("ramp_max", 32'(bus.duty), 20);
        step(19);  chk_out("pre_fault", 20, 1, 0, 1);
        step(1);   chk_out("fault", 0, 0, 1, 0);
        bus.fault_clr = 1'b1; step(1); bus.fault_clr = 1'b0;
        chk_out("clr_run_hi", 0, 0, 1, 0);
        bus.run = 1'b0; bus.fault_clr = 1'b1; step(1); bus.fault_clr = 1'b0;
        chk_out("clr_run_lo", 0, 0, 0, 0);
        step(2);   chk_out("idle_after_clr", 0, 0, 0, 0);

        // Stop at duty 7 right after entering REGULATE
        bus.run = 1'b1;
        step(1);
        step(56);  chk("ramp_d7", 32'(bus.duty), 7);
        bus.fb = 1'b1;
        step(8);   chk_out("reg_d7", 7, 1, 0, 1);
        bus.run = 1'b0;
        step(1);   chk_out("stop_d7", 0, 0, 0, 0);
        bus.fb = 1'b0;
        step(3);

        // Stop request coinciding with the terminal saturated tick
        bus.run = 1'b1;
        step(1);
        step(179);
        bus.run = 1'b0;
        step(1);   chk_out("sim_fault", 0, 0, 1, 0);
        bus.fault_clr = 1'b1; step(1); bus.fault_clr = 1'b0;
        chk_out("sim_clr", 0, 0, 0, 0);

        // Reset in REGULATE
        bus.run = 1'b1;
        step(1);
        step(170); chk_out("pre_reset", 20, 1, 0, 1);
        reset = 1'b1;
        step(1);   chk_out("mid_reset", 0, 0, 0, 0);
        bus.run = 1'b0;
        reset = 1'b0;
        step(2);
`else
        // Direct entry into REGULATE at DUTY_MIN
        bus.run = 1'b1;
        step(1);  chk_out("start", 2, 1, 0, 1);
        step(3);  chk("pre_step", 32'(bus.duty), 2);
        step(1);  chk("first_step", 32'(bus.duty), 3);
        step(16); chk("reg_d7", 32'(bus.duty), 7);
        bus.run = 1'b0;
        step(1);  chk_out("stop_d7", 0, 0, 0, 0);
        step(2);

        // Feedback drives duty down to the lower clamp
        bus.run = 1'b1;
        step(1);
        step(20); chk("up_d7", 32'(bus.duty), 7);
        bus.fb = 1'b1;
        step(4);  chk("down_d6", 32'(bus.duty), 6);
        step(4);  chk("down_d5", 32'(bus.duty), 5);
        step(12); chk("down_d2", 32'(bus.duty), 2);
        step(4);  chk_out("hold_min", 2, 1, 0, 1);
        bus.run = 1'b0;
        bus.fb  = 1'b0;
        step(1);  chk_out("stop_min", 0, 0, 0, 0);
        step(3);

        // Saturation counter cleared by one feedback tick, then fault
        bus.run = 1'b1;
        step(1);
        step(72); chk("ramp_max", 32'(bus.duty), 20);
        step(8);
        bus.fb = 1'b1;
        step(4);  chk("sat_break", 32'(bus.duty), 19);
        bus.fb = 1'b0;
        step(15); chk_out("pre_fault", 20, 1, 0, 1);
        step(1);  chk_out("fault", 0, 0, 1, 0);
        bus.fault_clr = 1'b1; step(1); bus.fault_clr = 1'b0;
        chk_out("clr_run_hi", 0, 0, 1, 0);
        bus.run = 1'b0; bus.fault_clr = 1'b1; step(1); bus.fault_clr = 1'b0;
        chk_out("clr_run_lo", 0, 0, 0, 0);
        step(2);

        // Stop request coinciding with the terminal saturated tick
        bus.run = 1'b1;
        step(1);
        step(83);
        bus.run = 1'b0;
        step(1);  chk_out("sim_fault", 0, 0, 1, 0);
        bus.fault_clr = 1'b1; step(1); bus.fault_clr = 1'b0;
        chk_out("sim_clr", 0, 0, 0, 0);

        // Reset in REGULATE
        bus.run = 1'b1;
        step(1);
        step(10); chk_out("pre_reset", 4, 1, 0, 1);
        reset = 1'b1;
        step(1);  chk_out("mid_reset", 0, 0, 0, 0);
        bus.run = 1'b0;
        reset = 1'b0;
        step(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pwm_duty_controller
`default_nettype wire
